// File: rtl/sim_video_capture.sv
// Video capture tap: packs active-area pixels with coordinates and frame markers
// into a show-ahead FIFO drained over valid/ready, and reports frame statistics.
module sim_video_capture #(
  parameter int FIFO_AW = 4,
  parameter int CNT_W   = 10
) (
  input  logic             CLK_VIDEO,
  input  logic             reset,
  input  logic             ce_pix,
  input  logic [7:0]       r,
  input  logic [7:0]       g,
  input  logic [7:0]       b,
  input  logic             hs,
  input  logic             vs,
  input  logic             hb,
  input  logic             vb,
  input  logic             enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [23:0]      out_data,
  output logic [CNT_W-1:0] out_x,
  output logic [CNT_W-1:0] out_y,
  output logic             out_sof,
  output logic             out_eol,
  output logic [CNT_W-1:0] frame_width,
  output logic [CNT_W-1:0] frame_height,
  output logic             frame_done,
  output logic [15:0]      frame_count,
  output logic             overflow
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_VB = 2'd1;
  localparam logic [1:0] S_ARMED   = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  typedef struct packed {
    logic [23:0]      data;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             sof;
    logic             eol;
  } entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Syncs travel with the video bus but framing relies on blanking only.
  logic unused_sync;
  assign unused_sync = hs ^ vs;

  logic [1:0]       state_q, state_d;
  logic             hb_q, vb_q;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             stg_vld_q, stg_vld_d;
  logic [23:0]      stg_data_q, stg_data_d;
  logic [CNT_W-1:0] stg_x_q, stg_x_d, stg_y_q, stg_y_d;
  logic             stg_sof_q, stg_sof_d;
  logic [CNT_W-1:0] width_q, width_d, height_q, height_d;
  logic             done_q, done_d;
  logic [15:0]      count_q, count_d;
  logic             ovf_q, ovf_d;

  logic active, hb_rise, vb_rise, in_cap, start, take, line_end, flush, frame_end;

  assign active    = ce_pix & ~hb & ~vb;
  assign hb_rise   = ce_pix & ~hb_q & hb;
  assign vb_rise   = ce_pix & ~vb_q & vb;
  assign in_cap    = (state_q == S_CAPTURE);
  assign start     = (state_q == S_ARMED) & enable & active;
  assign take      = start | (in_cap & active);
  // A staged pixel always exists once a line has seen an active pixel.
  assign line_end  = in_cap & hb_rise & stg_vld_q;
  assign flush     = in_cap & stg_vld_q & (hb_rise | vb_rise);
  assign frame_end = in_cap & vb_rise;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    stg_vld_d  = stg_vld_q;
    stg_data_d = stg_data_q;
    stg_x_d    = stg_x_q;
    stg_y_d    = stg_y_q;
    stg_sof_d  = stg_sof_q;
    width_d    = width_q;
    height_d   = height_q;
    count_d    = count_q;
    done_d     = frame_end;

    unique case (state_q)
      S_IDLE:    if (enable) state_d = S_WAIT_VB;
      S_WAIT_VB: if (!enable) state_d = S_IDLE;
                 else if (ce_pix && vb) state_d = S_ARMED;
      S_ARMED:   if (!enable) state_d = S_IDLE;
                 else if (active) state_d = S_CAPTURE;
      S_CAPTURE: if (vb_rise) state_d = enable ? S_ARMED : S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (take) begin
      stg_vld_d  = 1'b1;
      stg_data_d = {r, g, b};
      stg_x_d    = start ? '0 : x_q;
      stg_y_d    = start ? '0 : y_q;
      stg_sof_d  = start;
      x_d        = start ? sat_inc('0) : sat_inc(x_q);
      y_d        = start ? '0 : y_q;
    end else if (flush) begin
      stg_vld_d = 1'b0;
    end

    if (line_end) begin
      x_d = '0;
      y_d = sat_inc(y_q);
    end

    if (flush && stg_y_q == '0) width_d = stg_x_q + 1'b1;

    if (frame_end) begin
      height_d = y_d;
      count_d  = count_q + 16'd1;
    end
  end

  // FIFO
  entry_t           mem [2**FIFO_AW];
  entry_t           push_entry, head;
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0] cnt_q;
  logic             push, pop, full, wr_en;

  assign push       = stg_vld_q & (take | flush);
  assign push_entry = '{data: stg_data_q, x: stg_x_q, y: stg_y_q, sof: stg_sof_q, eol: flush};
  assign full       = (cnt_q == FULL_CNT);
  assign pop        = out_valid & out_ready;
  assign wr_en      = push & (~full | pop);
  assign ovf_d      = ovf_q | (push & full & ~pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hb_q       <= 1'b0;
      vb_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      stg_vld_q  <= 1'b0;
      stg_data_q <= '0;
      stg_x_q    <= '0;
      stg_y_q    <= '0;
      stg_sof_q  <= 1'b0;
      width_q    <= '0;
      height_q   <= '0;
      done_q     <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      if (ce_pix) begin
        hb_q <= hb;
        vb_q <= vb;
      end
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      stg_vld_q  <= stg_vld_d;
      stg_data_q <= stg_data_d;
      stg_x_q    <= stg_x_d;
      stg_y_q    <= stg_y_d;
      stg_sof_q  <= stg_sof_d;
      width_q    <= width_d;
      height_q   <= height_d;
      done_q     <= done_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: storage is not reset; the occupancy count alone decides what is valid.
  always_ff @(posedge CLK_VIDEO) begin
    if (wr_en) mem[wr_ptr_q] <= push_entry;
  end

  assign head      = mem[rd_ptr_q];
  assign out_valid = (cnt_q != '0);
  assign out_data  = out_valid ? head.data : '0;
  assign out_x     = out_valid ? head.x    : '0;
  assign out_y     = out_valid ? head.y    : '0;
  assign out_sof   = out_valid & head.sof;
  assign out_eol   = out_valid & head.eol;

  assign frame_width  = width_q;
  assign frame_height = height_q;
  assign frame_done   = done_q;
  assign frame_count  = count_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_sim_video_capture.sv
// Randomized bench for sim_video_capture: frames are generated from geometry and
// the expected beat stream and FIFO occupancy come from a transaction-level model.
module tb_sim_video_capture;

  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int MAXC  = 15;
  localparam int HBL   = 2;

  typedef struct {
    logic [23:0] data;
    int          x;
    int          y;
    bit          sof;
    bit          eol;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset, ce_pix, hs, vs, hb, vb, enable, out_ready;
  logic [7:0]    r, g, b;
  logic          out_valid, out_sof, out_eol, frame_done, overflow;
  logic [23:0]   out_data;
  logic [CW-1:0] out_x, out_y, frame_width, frame_height;
  logic [15:0]   frame_count;

  sim_video_capture #(.FIFO_AW(AW), .CNT_W(CW)) dut (
    .CLK_VIDEO(clk), .reset(reset), .ce_pix(ce_pix),
    .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .hb(hb), .vb(vb),
    .enable(enable), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_x(out_x), .out_y(out_y),
    .out_sof(out_sof), .out_eol(out_eol),
    .frame_width(frame_width), .frame_height(frame_height),
    .frame_done(frame_done), .frame_count(frame_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  beat_t q[$];
  bit    m_ovf, m_done;
  int    m_count, m_width, m_height;
  int    rdy_mode;  // 0 never, 1 always, 2 random, 3 only when model FIFO is full

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int satc(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic compare();
    check("valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("data", out_data, q[0].data);
      check("x",    out_x,    q[0].x);
      check("y",    out_y,    q[0].y);
      check("sof",  out_sof,  q[0].sof);
      check("eol",  out_eol,  q[0].eol);
    end
    check("overflow",    overflow,    m_ovf);
    check("frame_done",  frame_done,  m_done);
    check("frame_count", frame_count, m_count);
    if (m_done) begin
      check("frame_height", frame_height, m_height);
      if (m_width <= MAXC) check("frame_width", frame_width, m_width);
    end
  endtask

  // One CLK_VIDEO cycle: drive, clock, advance the model, then sample.
  task automatic cyc(input bit ce, input bit hbv, input bit vbv, input logic [23:0] rgb,
                     input bit do_push, input beat_t pb, input bit do_done,
                     input int w, input int h);
    bit pop, was_full;
    ce_pix = ce; hb = hbv; vb = vbv; {r, g, b} = rgb;
    hs = 1'($urandom); vs = 1'($urandom);
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      2:       out_ready = 1'($urandom);
      default: out_ready = (q.size() >= DEPTH);
    endcase
    @(posedge clk);
    was_full = (q.size() == DEPTH);
    pop = (q.size() > 0) && out_ready;
    if (pop) void'(q.pop_front());
    if (do_push) begin
      if (!was_full || pop) q.push_back(pb);
      else m_ovf = 1'b1;
    end
    m_done = do_done;
    if (do_done) begin
      m_count  = (m_count + 1) & 16'hFFFF;
      m_width  = w;
      m_height = h;
    end
    #1 compare();
  endtask

  task automatic idle_cyc(input int n);
    beat_t z;
    z = '{data: '0, x: 0, y: 0, sof: 0, eol: 0};
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'($urandom), 1'($urandom), 24'($urandom), 1'b0, z, 1'b0, 0, 0);
  endtask

  // Active lines 0..h-1 then vbl blanking lines; each line is w pixels plus HBL blank.
  // gap < 0 inserts 0..2 random ce_pix=0 cycles before each sample.
  task automatic gen_frame(input int w, input int h, input int vbl, input bit cap,
                           input int gap, input int en_line, input bit en_val,
                           input int abort_line);
    logic [23:0] prev = '0;
    for (int l = 0; l < h + vbl; l++) begin
      if (l == en_line) enable = en_val;
      for (int p = 0; p < w + HBL; p++) begin
        bit          hbv, vbv, push, done;
        beat_t       pb;
        logic [23:0] rgb;
        if (l == abort_line && p == 1) return;
        idle_cyc(gap < 0 ? int'($urandom_range(0, 2)) : gap);
        hbv  = (p >= w);
        vbv  = (l >= h);
        rgb  = 24'($urandom);
        push = cap && !vbv && p >= 1 && p <= w;
        pb   = '{data: prev, x: satc(p - 1), y: satc(l), sof: (p == 1 && l == 0), eol: (p == w)};
        done = cap && h > 0 && l == h && p == 0;
        cyc(1'b1, hbv, vbv, rgb, push, pb, done, w, satc(h));
        if (!hbv && !vbv) prev = rgb;
      end
    end
  endtask

  task automatic prelude();
    gen_frame(3, 0, 2, 1'b0, 0, -1, 1'b0, -1);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; ce_pix = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    q.delete();
    m_ovf = 0; m_done = 0; m_count = 0; m_width = 0; m_height = 0;
    #1;
    check("rst_valid",  out_valid,    0);
    check("rst_data",   out_data,     0);
    check("rst_ovf",    overflow,     0);
    check("rst_count",  frame_count,  0);
    check("rst_width",  frame_width,  0);
    check("rst_height", frame_height, 0);
    check("rst_done",   frame_done,   0);
    reset = 1'b0;
  endtask

  initial begin
    {r, g, b} = '0; hs = 0; vs = 0; hb = 0; vb = 0;
    rdy_mode = 1;
    do_reset();

    // Basic 4x3 frame, ce_pix every 2nd cycle, host always ready.
    enable = 1'b1; rdy_mode = 1;
    prelude();
    gen_frame(4, 3, 2, 1'b1, 1, -1, 1'b0, -1);
    check("t1_count", frame_count, 1);
    idle_cyc(4);

    // Host stalled: first 4 pixels held, the rest dropped, then drained.
    do_reset();
    enable = 1'b1; rdy_mode = 0;
    prelude();
    gen_frame(4, 3, 2, 1'b1, 1, -1, 1'b0, -1);
    check("t2_ovf", overflow, 1);
    enable = 1'b0; rdy_mode = 1;
    idle_cyc(6);

    // enable dropped mid-capture: frame completes, next frame ignored.
    do_reset();
    enable = 1'b1; rdy_mode = 2;
    prelude();
    gen_frame(4, 3, 2, 1'b1, -1, 1, 1'b0, -1);
    gen_frame(4, 3, 2, 1'b0, -1, -1, 1'b0, -1);
    rdy_mode = 1;
    idle_cyc(6);
    check("t3_count", frame_count, 1);

    // Reset mid-line with three entries queued, then confirm the block is idle.
    do_reset();
    enable = 1'b1; rdy_mode = 0;
    prelude();
    gen_frame(3, 2, 2, 1'b1, 0, -1, 1'b0, 1);
    check("t4_queued", out_valid, 1);
    do_reset();
    rdy_mode = 1;
    gen_frame(3, 2, 2, 1'b0, 0, -1, 1'b0, -1);

    // Host pops only when full, so every push onto a full FIFO has a pop beside it.
    do_reset();
    enable = 1'b1; rdy_mode = 3;
    prelude();
    gen_frame(6, 2, 2, 1'b1, -1, -1, 1'b0, -1);
    check("t5_ovf", overflow, 0);
    rdy_mode = 1;
    idle_cyc(6);

    // enable raised mid-frame: capture starts only with the following frame.
    do_reset();
    rdy_mode = 1;
    prelude();
    gen_frame(4, 3, 2, 1'b0, -1, 1, 1'b1, -1);
    gen_frame(4, 3, 2, 1'b1, -1, -1, 1'b0, -1);
    idle_cyc(6);

    // Coordinate saturation.
    do_reset();
    enable = 1'b1; rdy_mode = 1;
    prelude();
    gen_frame(20, 18, 2, 1'b1, 0, -1, 1'b0, -1);
    idle_cyc(6);

    // Random geometry, random host backpressure.
    for (int run = 0; run < 6; run++) begin
      do_reset();
      enable = 1'b1; rdy_mode = 2;
      prelude();
      for (int f = 0; f < 2; f++)
        gen_frame($urandom_range(1, 6), $urandom_range(1, 4), 2, 1'b1, -1, -1, 1'b0, -1);
      enable = 1'b0;
      idle_cyc(8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
